// File: rtl/stream_to_vga.sv
// stream_to_vga: pulls scaler pixels into a FIFO with credit-based requests and replays them on a VGA raster.
// Defining STREAM_TO_VGA_PATTERN_EN adds the pattern_sel input selecting a checkerboard for active video.
module stream_to_vga #(
    parameter int CHANNELS     = 3,
    parameter int CH_WIDTH     = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PULL_LATENCY = 4,
    parameter int H_ACTIVE     = 320,
    parameter int H_FP         = 8,
    parameter int H_SYNC       = 32,
    parameter int H_BP         = 40,
    parameter int V_ACTIVE     = 240,
    parameter int V_FP         = 3,
    parameter int V_SYNC       = 4,
    parameter int V_BP         = 6
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef STREAM_TO_VGA_PATTERN_EN
    input  logic                         pattern_sel,
`endif
    input  logic [CHANNELS*CH_WIDTH-1:0] dOut,
    input  logic                         dOutValid,
    output logic                         nextDout,
    output logic                         scaler_start,
    output logic [CHANNELS*CH_WIDTH-1:0] pix_out,
    output logic                         de,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         underflow
);

    localparam int DW      = CHANNELS * CH_WIDTH;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int SW      = CW + 1;
    localparam int PIXELS  = H_ACTIVE * V_ACTIVE;
    localparam int RW      = $clog2(PIXELS + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [RW-1:0] REQ_MAX = RW'(PIXELS);
    localparam logic [SW-1:0] CREDITS = SW'(FIFO_DEPTH);

    if (FIFO_DEPTH < PULL_LATENCY + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_to_vga: FIFO_DEPTH must be a power of two and at least PULL_LATENCY+2");
    end

    logic [HW-1:0] r_hCnt;
    logic [VW-1:0] r_vCnt;
    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [RW-1:0] r_reqCnt;
    logic          r_armed;
    logic          r_de;
    logic          r_hsync;
    logic          r_vsync;
    logic [DW-1:0] r_pix;
    logic          r_underflow;

    logic w_active;
    logic w_frameStart;
    logic w_credit;
    logic w_req;
    logic w_push;
    logic w_pop;

    assign w_active     = (r_hCnt < H_ACT) && (r_vCnt < V_ACT);
    assign w_frameStart = (r_hCnt == '0) && (r_vCnt == VS_BEG);
    // Words already requested but not yet returned hold a FIFO slot, so overflow cannot occur.
    assign w_credit     = ({1'b0, r_count} + {1'b0, r_outstanding}) < CREDITS;
    assign w_req        = r_armed && (r_reqCnt < REQ_MAX) && w_credit && !w_frameStart;
    assign w_push       = dOutValid && (r_discard == '0) && !w_frameStart;
    assign w_pop        = w_active && (r_count != '0);

    assign nextDout     = w_req;
    assign scaler_start = w_frameStart;
    assign pix_out      = r_pix;
    assign de           = r_de;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign underflow    = r_underflow;

`ifdef STREAM_TO_VGA_PATTERN_EN
    logic w_checker;
    assign w_checker = ((32'(r_hCnt) ^ 32'(r_vCnt)) & 32'd8) != 32'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (r_hCnt == H_LAST) begin
            r_hCnt <= '0;
            r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + VW'(1);
        end else begin
            r_hCnt <= r_hCnt + HW'(1);
        end
    end

    // In-flight words at frame start belong to the old scaler frame and are dropped on return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_discard     <= '0;
            r_reqCnt      <= '0;
            r_armed       <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req) - CW'(dOutValid);
            if (w_frameStart) begin
                r_discard <= r_outstanding - CW'(dOutValid);
                r_reqCnt  <= '0;
                r_armed   <= 1'b1;
            end else begin
                if (dOutValid && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_req) begin
                    r_reqCnt <= r_reqCnt + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (w_frameStart) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= dOut;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de        <= 1'b0;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_pix       <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_de    <= w_active;
            r_hsync <= !((r_hCnt >= HS_BEG) && (r_hCnt < HS_END));
            r_vsync <= !((r_vCnt >= VS_BEG) && (r_vCnt < VS_END));
            if (w_active && (r_count == '0) && r_armed) begin
                r_underflow <= 1'b1;
            end
            if (!w_active) begin
                r_pix <= '0;
`ifdef STREAM_TO_VGA_PATTERN_EN
            end else if (pattern_sel) begin
                r_pix <= w_checker ? '1 : '0;
`endif
            end else if (w_pop) begin
                r_pix <= r_mem[r_rdPtr];
            end else begin
                r_pix <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stream_to_vga.sv
// tb_stream_to_vga: drives stream_to_vga with a small raster and a latency-configurable scaler model,
// checking every output each clock against a queue-based reference of the display pipeline.
`timescale 1ns/1ps
module tb_stream_to_vga;

    localparam int DW         = 24;
    localparam int H_ACTIVE   = 8;
    localparam int H_FP       = 2;
    localparam int H_SYNC     = 2;
    localparam int H_BP       = 2;
    localparam int V_ACTIVE   = 4;
    localparam int V_FP       = 1;
    localparam int V_SYNC     = 1;
    localparam int V_BP       = 1;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME      = H_TOTAL * V_TOTAL;
    localparam int FIFO_DEPTH = 16;
    localparam int PIXELS     = H_ACTIVE * V_ACTIVE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] dOut = '0;
    logic          dOutValid = 1'b0;
    logic          nextDout;
    logic          scaler_start;
    logic [DW-1:0] pix_out;
    logic          de;
    logic          hsync;
    logic          vsync;
    logic          underflow;
`ifdef STREAM_TO_VGA_PATTERN_EN
    logic          pattern_sel = 1'b0;
`endif

    stream_to_vga #(
        .CHANNELS(3), .CH_WIDTH(8), .FIFO_DEPTH(FIFO_DEPTH), .PULL_LATENCY(4),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef STREAM_TO_VGA_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .dOut(dOut),
        .dOutValid(dOutValid),
        .nextDout(nextDout),
        .scaler_start(scaler_start),
        .pix_out(pix_out),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int cmpCount = 0;
    int errCount = 0;

    // Scaler model: in-order returns, per-frame pixel count restarted by scaler_start.
    int latency;
    int stallUntil;
    int scalerSeq;
    int lastRet;
    int pendTime[$];
    int pendData[$];

    // Reference model of the display pipeline, indexed by clocks since reset release.
    int cyc;
    int fifoQ[$];
    int mOut;
    int mDiscard;
    int mReq;
    bit mArmed;
    bit mUnder;
    bit expDe;
    bit expHs;
    bit expVs;
    int expPix;

    int reqSeen;
    int reqLastFrame;
    int shown[$];
    int shownLast[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmpCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        cyc = 0;
        fifoQ.delete();
        mOut = 0;
        mDiscard = 0;
        mReq = 0;
        mArmed = 1'b0;
        mUnder = 1'b0;
        expDe = 1'b0;
        expHs = 1'b1;
        expVs = 1'b1;
        expPix = 0;
        pendTime.delete();
        pendData.delete();
        scalerSeq = 0;
        lastRet = -1;
        stallUntil = 0;
        shown.delete();
        reqSeen = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_hsync"}, hsync, 1);
        checkOutput({tag, "_vsync"}, vsync, 1);
        checkOutput({tag, "_de"}, de, 0);
        checkOutput({tag, "_pix"}, 32'(pix_out), 0);
        checkOutput({tag, "_nextDout"}, nextDout, 0);
        checkOutput({tag, "_start"}, scaler_start, 0);
        checkOutput({tag, "_underflow"}, underflow, 0);
    endtask

    task automatic checkSequence(input string tag);
        checkOutput({tag, "_len"}, shownLast.size(), PIXELS);
        for (int i = 0; i < shownLast.size() && i < PIXELS; i++) begin
            checkOutput(tag, shownLast[i], i);
        end
    endtask

    task automatic checkBlack(input string tag);
        checkOutput({tag, "_len"}, shownLast.size(), PIXELS);
        for (int i = 0; i < shownLast.size() && i < PIXELS; i++) begin
            checkOutput(tag, shownLast[i], 0);
        end
    endtask

    task automatic applyStimulus(input int nCycles);
        for (int n = 0; n < nCycles; n++) begin
            int  h;
            int  v;
            int  size;
            int  data;
            bit  fs;
            bit  act;
            bit  req;
            bit  valid;
            bit  pop;
            @(negedge clk);
            h    = cyc % H_TOTAL;
            v    = (cyc / H_TOTAL) % V_TOTAL;
            fs   = (h == 0) && (v == V_ACTIVE + V_FP);
            act  = (h < H_ACTIVE) && (v < V_ACTIVE);
            size = fifoQ.size();
            req  = mArmed && (mReq < PIXELS) && (size + mOut < FIFO_DEPTH) && !fs;

            checkOutput("nextDout", nextDout, req);
            checkOutput("scaler_start", scaler_start, fs);
            checkOutput("de", de, expDe);
            checkOutput("hsync", hsync, expHs);
            checkOutput("vsync", vsync, expVs);
            checkOutput("pix_out", 32'(pix_out), expPix);
            checkOutput("underflow", underflow, mUnder);

            if (fs) begin
                shownLast = shown;
                shown.delete();
                reqLastFrame = reqSeen;
                reqSeen = 0;
            end
            if (de) shown.push_back(int'(pix_out));
            if (nextDout) reqSeen++;

            if (scaler_start) scalerSeq = 0;
            if (nextDout) begin
                int t = cyc + latency;
                if (t <= lastRet) t = lastRet + 1;
                pendTime.push_back(t);
                pendData.push_back(scalerSeq);
                scalerSeq++;
                lastRet = t;
            end
            valid = 1'b0;
            data = 0;
            if (pendTime.size() > 0 && pendTime[0] <= cyc && cyc >= stallUntil) begin
                valid = 1'b1;
                data = pendData.pop_front();
                void'(pendTime.pop_front());
            end
            dOutValid = valid;
            dOut = DW'(data);

            expDe = act;
            expHs = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
            expVs = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
            pop = act && (size > 0);
            if (act && size == 0 && mArmed) mUnder = 1'b1;
            expPix = 0;
            if (act && pop) expPix = fifoQ[0];
`ifdef STREAM_TO_VGA_PATTERN_EN
            if (act && pattern_sel) expPix = (((h ^ v) & 8) != 0) ? 32'h00FF_FFFF : 0;
`endif
            if (pop) void'(fifoQ.pop_front());
            mOut = mOut + int'(req) - int'(valid);
            if (fs) begin
                fifoQ.delete();
                mDiscard = mOut;
                mReq = 0;
                mArmed = 1'b1;
            end else begin
                if (valid) begin
                    if (mDiscard > 0) mDiscard--;
                    else fifoQ.push_back(data);
                end
                if (req) mReq++;
            end
            cyc++;
        end
    endtask

    initial begin
        latency = 4;
        reqLastFrame = 0;
        resetModel();
        repeat (3) @(negedge clk);
        checkResetOutputs("por");
        @(posedge clk);
        #2 rst = 1'b0;

        // Frame 1 is unarmed and black; frame 2 shows the first scaler frame.
        applyStimulus(FRAME);
        checkBlack("frame1_black");
        checkOutput("frame1_underflow", underflow, 0);
        applyStimulus(FRAME);
        checkSequence("frame2_pixels");
        checkOutput("frame2_requests", reqLastFrame, PIXELS);

        // Stall returns from mid-line 0 long enough to drain the FIFO.
        applyStimulus(3);
        stallUntil = cyc + 30;
        applyStimulus(FRAME - 3);
        checkOutput("stall_underflow", underflow, 1);
        applyStimulus(FRAME);
        checkOutput("underflow_sticky", underflow, 1);
        checkSequence("post_stall_pixels");
        checkOutput("post_stall_requests", reqLastFrame, PIXELS);

        // Long latency leaves words in flight across frame starts.
        latency = 40;
        applyStimulus(2 * FRAME);
        latency = 4;
        applyStimulus(3 * FRAME);
        checkSequence("post_flush_pixels");
        checkOutput("post_flush_requests", reqLastFrame, PIXELS);

        applyStimulus(20);
        checkOutput("pre_reset_underflow", underflow, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        dOutValid = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("held_rst");
        resetModel();
        rst = 1'b0;
        applyStimulus(FRAME);
        checkBlack("rst_frame1_black");
        checkOutput("rst_frame1_underflow", underflow, 0);
        applyStimulus(FRAME);
        checkSequence("rst_frame2_pixels");

`ifdef STREAM_TO_VGA_PATTERN_EN
        pattern_sel = 1'b1;
        applyStimulus(FRAME);
        checkOutput("pattern_requests", reqLastFrame, PIXELS);
        pattern_sel = 1'b0;
        applyStimulus(2 * FRAME);
        checkSequence("after_pattern_pixels");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
